// File: rtl/decode_sequencer.sv
// decode_sequencer: fetch/execute sequencer that tracks the microcode
// phase and handles interrupt entry, HALT, WAIT and phase overrun.
module decode_sequencer #(
  parameter int INSN_W = 16,
  parameter int PHASE_W = 3,
  parameter int KIND_W = 7,
  parameter logic [INSN_W-1:0] INT_OPCODE = 16'h8000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INSN_W-1:0]         instr_in,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [KIND_W-1:0]         dec_kind,
  input  logic                      dec_halt,
  input  logic                      dec_wait,
  input  logic                      dec_ei,
  input  logic                      dec_di,
  input  logic                      dec_rti,
  input  logic                      uc_last,
  input  logic                      irq,
  output logic [INSN_W-1:0]         ir,
  output logic [PHASE_W-1:0]        phase,
  output logic                      fetch,
  output logic                      exc_triggered,
  output logic [PHASE_W+KIND_W-1:0] ucode_addr,
  output logic                      ie,
  output logic                      halted,
  output logic                      waiting,
  output logic                      uc_overrun
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_HALT,
    ST_WAIT
  } state_t;

  state_t state;

  logic is_exec;
  logic ovf;
  logic fin;
  logic ie_next;
  logic halt_ok;
  logic wait_ok;
  logic enter_irq;

  assign is_exec = (state == ST_EXEC);
  assign ovf     = is_exec && (phase == '1) && !uc_last;
  assign fin     = is_exec && (uc_last || ovf);
  assign halt_ok = !exc_triggered && dec_halt;
  assign wait_ok = !exc_triggered && dec_wait;

  assign fetch   = (state == ST_FETCH);
  assign halted  = (state == ST_HALT);
  assign waiting = (state == ST_WAIT);

  assign instr_ready = !rst && fetch && !(irq && ie);
  assign ucode_addr  = {phase, dec_kind};

  // interrupt-enable value taking effect at instruction end
  always_comb begin
    ie_next = ie;
    if (exc_triggered) begin
      if (dec_rti) ie_next = 1'b1;
    end else if (dec_di) begin
      ie_next = 1'b0;
    end else if (dec_ei || dec_rti) begin
      ie_next = 1'b1;
    end
  end

  // any path that jumps straight into the interrupt instruction
  always_comb begin
    enter_irq = 1'b0;
    if (fetch && irq && ie) enter_irq = 1'b1;
    if (waiting && irq && ie) enter_irq = 1'b1;
    if (fin && !halt_ok && !wait_ok && irq && ie_next)
      enter_irq = 1'b1;
  end

  // sequencer state, instruction register and phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_FETCH;
      ir            <= '0;
      phase         <= '0;
      ie            <= 1'b0;
      exc_triggered <= 1'b0;
      uc_overrun    <= 1'b0;
    end else begin
      if (ovf) uc_overrun <= 1'b1;
      if (enter_irq) begin
        ir            <= INT_OPCODE;
        phase         <= '0;
        exc_triggered <= 1'b1;
        ie            <= 1'b0;
        state         <= ST_EXEC;
      end else begin
        unique case (state)
          ST_FETCH: begin
            if (instr_valid) begin
              ir            <= instr_in;
              phase         <= '0;
              exc_triggered <= 1'b0;
              state         <= ST_EXEC;
            end
          end
          ST_EXEC: begin
            if (!fin) begin
              phase <= phase + PHASE_W'(1);
            end else begin
              phase         <= '0;
              ie            <= ie_next;
              exc_triggered <= 1'b0;
              if (halt_ok)      state <= ST_HALT;
              else if (wait_ok) state <= ST_WAIT;
              else              state <= ST_FETCH;
            end
          end
          ST_HALT: begin
            state <= ST_HALT;
          end
          ST_WAIT: begin
            if (irq) state <= ST_FETCH;
          end
          default: state <= ST_FETCH;
        endcase
      end
    end
  end

endmodule
